// File: rtl/uart_tx_buffered.sv
// UART transmitter with a small input FIFO. Frames are start, LSB-first data,
// optional parity and one or two stop bits. Every bit lasts one baud tick interval.
module uart_tx_buffered #(
  parameter int DataWidth = 8,
  parameter int FifoDepth = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             tick_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [DataWidth-1:0]             data_i,
  input  logic [1:0]                       cfg_parity_i,
  input  logic                             cfg_stop2_i,
  output logic                             txd_o,
  output logic                             busy_o,
  output logic [$clog2(FifoDepth+1)-1:0]   level_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int LvlW = $clog2(FifoDepth + 1);
  localparam int CntW = $clog2(DataWidth + 1);
  localparam logic [LvlW-1:0] LevelFull = LvlW'(FifoDepth);
  localparam logic [CntW-1:0] LastCount = CntW'(DataWidth);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DataWidth-1:0] head_word;

  // ready depends on the registered level only, so a full FIFO refuses a
  // push even in the cycle the transmitter pops from it.
  assign ready_o    = (level_q != LevelFull);
  assign push       = valid_i && ready_o;
  assign fifo_empty = (level_q == '0);
  assign head_word  = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointer/level registers; reset empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // ---------------------------------------------------------------- serialiser
  state_t               state_q, state_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_due_q, stop_due_d;
  logic                 txd_q, txd_d;
  logic                 load_frame;

  assign txd_o  = txd_q;
  assign busy_o = (state_q != S_IDLE);

  // Next-state logic; nothing moves except on a baud tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_due_d = stop_due_q;
    txd_d      = txd_q;
    load_frame = 1'b0;

    if (tick_i) begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            load_frame = 1'b1;
          end
        end
        S_START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          count_d = CntW'(1);
          state_d = S_DATA;
        end
        S_DATA: begin
          if (count_q < LastCount) begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            count_d = count_q + 1'b1;
          end else if (par_en_q) begin
            txd_d   = par_bit_q;
            state_d = S_PARITY;
          end else begin
            txd_d      = 1'b1;
            stop_due_d = stop2_q;
            state_d    = S_STOP;
          end
        end
        S_PARITY: begin
          txd_d      = 1'b1;
          stop_due_d = stop2_q;
          state_d    = S_STOP;
        end
        S_STOP: begin
          if (stop_due_q) begin
            // second stop bit: line stays high for one more interval
            stop_due_d = 1'b0;
          end else if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end

    // Starting a frame: take the head word and freeze the line config for it.
    if (load_frame) begin
      shift_d    = head_word;
      par_en_d   = (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
      par_bit_d  = (cfg_parity_i == 2'b10) ? ~(^head_word) : (^head_word);
      stop2_d    = cfg_stop2_i;
      stop_due_d = 1'b0;
      count_d    = '0;
      txd_d      = 1'b0;
      state_d    = S_START;
    end
  end

  assign pop = load_frame;

  // Serialiser state; reset abandons any frame and drives the line high at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_due_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_due_q <= stop_due_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: table of single frames plus hand-written
// sequences for FIFO-full, back-to-back, reset mid-frame and mid-frame config change.
module tb_uart_tx_buffered;

  localparam int GAP = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic [1:0] cfg_parity_i = 2'b00;
  logic       cfg_stop2_i = 1'b0;
  logic       txd_o;
  logic       busy_o;
  logic [2:0] level_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_buffered #(.DataWidth(8), .FifoDepth(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_i       (tick_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .cfg_parity_i (cfg_parity_i),
    .cfg_stop2_i  (cfg_stop2_i),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  par;
    logic        stop2;
    logic [15:0] bits;   // bit i = expected line value after tick i
    int          len;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick_once();
    tick_i = 1'b1;
    @(negedge clk_i);
    tick_i = 1'b0;
    repeat (GAP) @(negedge clk_i);
  endtask

  task automatic push_word(input logic [7:0] d);
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic expect_seq(input string name, input logic [63:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      tick_once();
      chk($sformatf("%s txd[%0d]", name, i), 32'(txd_o), 32'(bits[i]));
      chk($sformatf("%s busy[%0d]", name, i), 32'(busy_o), 32'd1);
    end
  endtask

  task automatic expect_idle(input string name);
    tick_once();
    chk($sformatf("%s idle txd", name), 32'(txd_o), 32'd1);
    chk($sformatf("%s idle busy", name), 32'(busy_o), 32'd0);
    chk($sformatf("%s idle level", name), 32'(level_o), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{8'hA5, 2'b01, 1'b1, 16'({2'b11, 1'b0, 8'hA5, 1'b0}), 12};
    vecs[2] = '{8'hA5, 2'b10, 1'b1, 16'({2'b11, 1'b1, 8'hA5, 1'b0}), 12};
    vecs[3] = '{8'h3C, 2'b11, 1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10};
    vecs[4] = '{8'h01, 2'b01, 1'b0, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vecs[5] = '{8'hFF, 2'b10, 1'b0, 16'({1'b1, 1'b1, 8'hFF, 1'b0}), 11};
    vecs[6] = '{8'h00, 2'b10, 1'b1, 16'({2'b11, 1'b1, 8'h00, 1'b0}), 12};

    // Reset, then idle ticks with no traffic
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 100; i++) begin
      tick_once();
      chk($sformatf("rst_idle[%0d]", i),
          {28'd0, txd_o, busy_o, ready_o, 1'b0} | 32'(level_o << 4),
          {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    end

    // Single-frame table
    for (int v = 0; v < 7; v++) begin
      chk($sformatf("v%0d ready", v), 32'(ready_o), 32'd1);
      cfg_parity_i = vecs[v].par;
      cfg_stop2_i  = vecs[v].stop2;
      push_word(vecs[v].data);
      chk($sformatf("v%0d level", v), 32'(level_o), 32'd1);
      expect_seq($sformatf("v%0d", v), 64'(vecs[v].bits), vecs[v].len);
      expect_idle($sformatf("v%0d", v));
      $display("vector %0d data=%02h par=%0d stop2=%0d done", v, vecs[v].data,
               vecs[v].par, vecs[v].stop2);
    end

    // Fill FIFO: 5 offered, 4 accepted; push refused during pop while full
    cfg_parity_i = 2'b00;
    cfg_stop2_i  = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = 8'(8'h11 * (i + 1));
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    chk("full ready", 32'(ready_o), 32'd0);
    chk("full level", 32'(level_o), 32'd4);
    tick_i  = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h66;
    @(negedge clk_i);
    tick_i  = 1'b0;
    valid_i = 1'b0;
    chk("full pop txd", 32'(txd_o), 32'd0);
    chk("full pop level", 32'(level_o), 32'd3);
    chk("full pop ready", 32'(ready_o), 32'd1);
    repeat (GAP) @(negedge clk_i);
    expect_seq("b2b", 64'({1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
                           1'b1, 8'h22, 1'b0, 1'b1, 8'h11}), 39);
    expect_idle("b2b");
    $display("back-to-back burst done");

    // Reset in the middle of DATA of 0x3C with another word queued
    push_word(8'h3C);
    tick_once();
    push_word(8'h99);
    chk("rstmid level pre", 32'(level_o), 32'd1);
    tick_once();
    tick_once();
    chk("rstmid txd d1", 32'(txd_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rstmid txd", 32'(txd_o), 32'd1);
    chk("rstmid busy", 32'(busy_o), 32'd0);
    chk("rstmid level", 32'(level_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) expect_idle($sformatf("rstmid post%0d", i));
    push_word(8'h55);
    expect_seq("after_rst", 64'({1'b1, 8'h55, 1'b0}), 10);
    expect_idle("after_rst");
    $display("reset mid-frame done");

    // Config change mid-frame only affects the next frame
    cfg_parity_i = 2'b00;
    push_word(8'h0F);
    push_word(8'h01);
    expect_seq("cfg f1a", 64'({1'b1, 8'h0F, 1'b0}), 3);
    cfg_parity_i = 2'b10;
    expect_seq("cfg f1b", 64'({1'b1, 8'h0F, 1'b0}) >> 3, 7);
    expect_seq("cfg f2", 64'({1'b1, 1'b0, 8'h01, 1'b0}), 11);
    expect_idle("cfg");
    $display("config change mid-frame done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
